sram_wait_ctrl: RTL and testbench
=================================

Name: sram_wait_ctrl

Overview:
- Parametrised successor to the single-cycle data memory. Word-addressed synchronous SRAM with configurable depth and width, plus programmable wait-state latency.
- Uses a request/ready handshake so the MEM stage of the pipeline can freeze while an access is in flight.
- Sits between the MEM stage and the pipeline hazard/freeze logic.
- Read data is registered. The block never drives high-Z.

Parameters:
- DATA_W, 32, data word width in bits; multiple of 8.
- ADDR_W, 32, byte-address width.
- DEPTH, 64, number of words; power of 2, at least 2.
- WAIT_CYCLES, 2, wait states inserted before completion; integer from 0 to 15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request; held until ready.
- rd_en  in  1  read request; held until ready.
- address  in  ADDR_W  byte address; held until ready.
- write_data  in  DATA_W  store data; held until ready.
- byte_en  in  DATA_W/8  byte-lane write mask; exists only with SRAM_BYTE_WRITE_EN.
- read_data  out  DATA_W  registered read result.
- ready  out  1  transaction complete this cycle; pipeline freeze = request & ~ready.

Behaviour:
- Single clock clk. rst is synchronous and active-high.
- Word index:
  - OFS = clog2(DATA_W/8), IDX_W = clog2(DEPTH).
  - idx = address[OFS+IDX_W-1:OFS].
  - Upper address bits and byte-offset bits are ignored, so out-of-range addresses wrap. There is no error flag.
- FSM states: IDLE, WAIT, DONE.
  - IDLE → WAIT when (rd_en|wr_en) and WAIT_CYCLES>0; load cnt=WAIT_CYCLES-1.
  - IDLE → DONE when (rd_en|wr_en) and WAIT_CYCLES==0.
  - WAIT: if the request is still present, decrement cnt; when cnt==0, go to DONE and perform the access on that edge.
  - DONE: ready=1 for exactly one cycle, then unconditionally return to IDLE.
- Access timing:
  - The write commits, or read_data updates, on the edge entering DONE.
  - Latency from request assertion to ready=1 is WAIT_CYCLES+1 cycles.
  - Back-to-back requests: a request still asserted in the cycle after DONE is a new transaction. Minimum spacing is WAIT_CYCLES+2 cycles.
- Simultaneous wr_en and rd_en: treated as a write only. read_data is unchanged.
- Abort: if both enables drop while in WAIT, return to IDLE. No write occurs and read_data is unchanged.
- read_data holds the last completed read value; writes never alter it.
- ready is a registered-state decode: high only in DONE.
- Reset values: state=IDLE, cnt=0, ready=0, read_data=0. Memory contents are NOT cleared.
- Reset mid-transaction returns to IDLE on the next edge and suppresses any pending write.
- The memory array is not reset and requires no initial value. The bench must write before reading.

Optional Feature:
- Macro: SRAM_BYTE_WRITE_EN.
- Defined:
  - The byte_en port exists.
  - On write commit, only lanes with byte_en[i]=1 update bits [8i+7:8i]. Other lanes retain their value.
  - byte_en==0 completes the handshake normally but writes nothing.
- Undefined:
  - No byte_en port.
  - Every write updates the full word.

Decomposition:
- Shared package sram_pkg holds:
  - the state enum (IDLE/WAIT/DONE) and its 2-bit encoding;
  - the localparam functions for OFS and IDX_W;
  - default constants DATA_W_DEF=32 and DEPTH_DEF=64.
- Sub-module sram_array: plain synchronous-write, registered-read storage with optional per-lane write mask.
- Top sram_wait_ctrl: FSM, wait counter, handshake and index extraction. It instantiates sram_array.

Test Plan:
- Write then read, defaults:
  - wr_en, address=0x10, write_data=0xDEADBEEF held → ready=1 exactly 3 cycles after request.
  - Then rd_en @0x10 → ready after 3 cycles, read_data=0xDEADBEEF.
- Zero wait (WAIT_CYCLES=0): write 0x1234 @0x4, then read @0x4 → ready 1 cycle after each request, read_data=0x00001234.
- Wrap and simultaneous request:
  - Write 0xA5A5A5A5 @0x100 (DEPTH=64) → reading @0x0 returns 0xA5A5A5A5.
  - wr_en&rd_en together → write occurs, read_data unchanged.
- Abort and reset:
  - Drop wr_en during WAIT → IDLE, ready never asserts, memory word unchanged.
  - rst mid-WAIT → ready=0, read_data=0, no write.
- SRAM_BYTE_WRITE_EN: word=0x11223344, write 0xAABBCCDD with byte_en=4'b0101 → readback 0x11BB33DD.

Source files
------------

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared state encoding, index helpers and defaults for the wait-state SRAM
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } sram_state_t;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 64;

  // Byte-offset bits below the word index.
  function automatic int ofs_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int idx_bits(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sram_array.sv
// rtl/sram_array.sv - synchronous-write, registered-read word storage with per-lane write mask
module sram_array
  import sram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int LANES  = DATA_W / 8,
  parameter int IDX_W  = idx_bits(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [LANES-1:0]  wmask,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (wmask[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/sram_wait_ctrl.sv
// rtl/sram_wait_ctrl.sv - wait-state SRAM front end with request/ready handshake (option: SRAM_BYTE_WRITE_EN)
module sram_wait_ctrl
  import sram_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   write_data,
`ifdef SRAM_BYTE_WRITE_EN
  input  logic [DATA_W/8-1:0] byte_en,
`endif
  output logic [DATA_W-1:0]   read_data,
  output logic                ready
);

  localparam int LANES = DATA_W / 8;
  localparam int OFS   = ofs_bits(DATA_W);
  localparam int IDX_W = idx_bits(DEPTH);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  sram_state_t      state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic             req;
  logic             access;
  logic             we, re;
  logic [IDX_W-1:0] idx;
  logic [LANES-1:0] wmask;
  logic             unused_addr;

  assign req         = wr_en | rd_en;
  assign idx         = address[OFS+IDX_W-1:OFS];
  assign unused_addr = ^address;

`ifdef SRAM_BYTE_WRITE_EN
  assign wmask = byte_en;
`else
  assign wmask = {LANES{1'b1}};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // access marks the edge that enters DONE; that edge commits the write or loads read_data.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    access    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = DONE;
            access    = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_nxt = IDLE;
        end else if (cnt == 4'd0) begin
          state_nxt = DONE;
          access    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A simultaneous read and write is a write only.
  assign we    = access & wr_en & ~rst;
  assign re    = access & rd_en & ~wr_en & ~rst;
  assign ready = (state == DONE);

  sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .LANES  (LANES),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .re    (re),
    .idx   (idx),
    .wdata (write_data),
    .wmask (wmask),
    .rdata (read_data)
  );

endmodule

// File: tb/tb_sram_wait_ctrl.sv
// tb/tb_sram_wait_ctrl.sv - self-checking bench for sram_wait_ctrl at WAIT_CYCLES=2 and WAIT_CYCLES=0
module tb_sram_wait_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        wr_en2 = 1'b0, rd_en2 = 1'b0, ready2;
  logic [31:0] addr2 = '0, wdata2 = '0, rdata2;
  logic [3:0]  be2 = 4'hF;

  logic        wr_en0 = 1'b0, rd_en0 = 1'b0, ready0;
  logic [31:0] addr0 = '0, wdata0 = '0, rdata0;
  logic [3:0]  be0 = 4'hF;

  int checks = 0;
  int errors = 0;

  // Reference state: word memories and the last completed read of each instance.
  logic [31:0] mem2 [64];
  logic [31:0] mem0 [64];
  logic [31:0] rd2 = '0;
  logic [31:0] rd0 = '0;

  always #5 clk = ~clk;

  sram_wait_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_CYCLES(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en2),
    .rd_en      (rd_en2),
    .address    (addr2),
    .write_data (wdata2),
`ifdef SRAM_BYTE_WRITE_EN
    .byte_en    (be2),
`endif
    .read_data  (rdata2),
    .ready      (ready2)
  );

  sram_wait_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en0),
    .rd_en      (rd_en0),
    .address    (addr0),
    .write_data (wdata0),
`ifdef SRAM_BYTE_WRITE_EN
    .byte_en    (be0),
`endif
    .read_data  (rdata0),
    .ready      (ready0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    logic [3:0]  m;
`ifdef SRAM_BYTE_WRITE_EN
    m = be;
`else
    m = 4'hF;
`endif
    r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // One held request until ready; gap=0 means the request follows a DONE cycle directly.
  task automatic run_txn(input bit z, input logic wr, input logic rd, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be, input int gap,
                         output logic [31:0] got);
    int lat;
    int exp_lat;
    int idx;
    logic rdy;
    repeat (gap) begin @(posedge clk); #1; end
    if (z) begin
      wr_en0 = wr; rd_en0 = rd; addr0 = addr; wdata0 = data; be0 = be;
    end else begin
      wr_en2 = wr; rd_en2 = rd; addr2 = addr; wdata2 = data; be2 = be;
    end
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      rdy = z ? ready0 : ready2;
    end while (!rdy && lat < 40);
    if (z) begin wr_en0 = 1'b0; rd_en0 = 1'b0; end
    else   begin wr_en2 = 1'b0; rd_en2 = 1'b0; end

    idx = int'((addr >> 2) % 64);
    exp_lat = (z ? 0 : 2) + 1 + ((gap == 0) ? 1 : 0);
    if (z) begin
      if (wr) mem0[idx] = merge(mem0[idx], data, be);
      else if (rd) rd0 = mem0[idx];
    end else begin
      if (wr) mem2[idx] = merge(mem2[idx], data, be);
      else if (rd) rd2 = mem2[idx];
    end
    got = z ? rdata0 : rdata2;
    check(z ? "latency_w0" : "latency_w2", 32'(lat), 32'(exp_lat));
    check(z ? "read_data_w0" : "read_data_w2", got, z ? rd0 : rd2);
  endtask

  typedef struct {
    bit          z;
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [31:0] got;
    logic        saw;
    int          kind;
    logic [31:0] a;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h10,  32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h4,   32'h1234,     32'h0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h4,   32'h0,        32'h00001234};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h100, 32'hA5A5A5A5, 32'hDEADBEEF};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h0,   32'h0,        32'hA5A5A5A5};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h10,  32'h55AA55AA, 32'hA5A5A5A5};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 32'h10,  32'h0,        32'h55AA55AA};

    repeat (2) @(posedge clk);
    #1;
    check("reset_ready_w2", {31'b0, ready2}, 32'h0);
    check("reset_rdata_w2", rdata2, 32'h0);
    check("reset_ready_w0", {31'b0, ready0}, 32'h0);
    check("reset_rdata_w0", rdata0, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].z, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, 4'hF, 1, got);
      check($sformatf("table_%0d", i), got, vecs[i].exp_rd);
    end

    // Back-to-back request straight out of DONE costs one extra cycle.
    run_txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'hF, 0, got);
    run_txn(1'b1, 1'b1, 1'b0, 32'h8, 32'h0000BEEF, 4'hF, 1, got);
    run_txn(1'b1, 1'b0, 1'b1, 32'h8, 32'h0, 4'hF, 0, got);

    // Abort: enables drop during WAIT.
    run_txn(1'b0, 1'b1, 1'b0, 32'h20, 32'h0BADF00D, 4'hF, 1, got);
    @(posedge clk); #1;
    wr_en2 = 1'b1; addr2 = 32'h20; wdata2 = 32'hFFFFFFFF; be2 = 4'hF;
    @(posedge clk); #1;
    wr_en2 = 1'b0;
    saw = ready2;
    repeat (4) begin @(posedge clk); #1; saw |= ready2; end
    check("abort_no_ready", {31'b0, saw}, 32'h0);
    run_txn(1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 4'hF, 1, got);
    check("abort_mem_kept", got, 32'h0BADF00D);

    // Reset in the middle of WAIT suppresses the pending write.
    @(posedge clk); #1;
    wr_en2 = 1'b1; addr2 = 32'h20; wdata2 = 32'h12345678;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ready", {31'b0, ready2}, 32'h0);
    check("rst_mid_rdata", rdata2, 32'h0);
    check("rst_mid_rdata_w0", rdata0, 32'h0);
    rst = 1'b0; wr_en2 = 1'b0;
    rd2 = '0; rd0 = '0;
    run_txn(1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 4'hF, 1, got);
    check("rst_no_write", got, 32'h0BADF00D);

`ifdef SRAM_BYTE_WRITE_EN
    run_txn(1'b0, 1'b1, 1'b0, 32'h40, 32'h11223344, 4'hF, 1, got);
    run_txn(1'b0, 1'b1, 1'b0, 32'h40, 32'hAABBCCDD, 4'b0101, 1, got);
    run_txn(1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 4'hF, 1, got);
    check("byte_lanes", got, 32'h11BB33DD);
    run_txn(1'b0, 1'b1, 1'b0, 32'h40, 32'h99999999, 4'b0000, 1, got);
    run_txn(1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 4'hF, 1, got);
    check("byte_none", got, 32'h11BB33DD);
`endif

    // Randomized traffic over eight words with scrambled upper/offset address bits.
    for (int z = 0; z < 2; z++) begin
      for (int w = 0; w < 8; w++)
        run_txn(z[0], 1'b1, 1'b0, 32'(w << 2), $urandom, 4'hF, 1, got);
      for (int n = 0; n < 30; n++) begin
        kind = int'($urandom_range(0, 3));
        a = ($urandom & 32'hFFFFFF00) | 32'($urandom_range(0, 7) << 2) | ($urandom & 32'h3);
        run_txn(z[0], kind == 0 || kind == 2, kind != 0, a, $urandom, 4'($urandom),
                int'($urandom_range(0, 2)), got);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
